hsi_tx_scheduler: RTL and testbench

//  Sequences the HSI master serializer: arbitrates between BTC, SR, CCW and TM frame sources and starts one frame at a time.

---
 rtl/hsi_pkg.sv | 23 ++
 rtl/hsi_prio_arb.sv | 34 +++
 rtl/hsi_tx_scheduler.sv | 147 ++++++++++++++
 tb/tb_hsi_tx_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_pkg.sv
// Shared constants for the HSI transmit scheduler: source codes, FSM state
// encoding and a counter-width helper.
package hsi_pkg;

    // Source codes, also the value driven on link_sel
    localparam logic [1:0] SRC_BTC = 2'd0;
    localparam logic [1:0] SRC_SR  = 2'd1;
    localparam logic [1:0] SRC_CCW = 2'd2;
    localparam logic [1:0] SRC_TM  = 2'd3;

    // Scheduler FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RETRY = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Bits needed to hold 0..max_val; never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hsi_prio_arb.sv
// Four-way fixed-priority picker (BTC > SR > CCW > TM) with a TM override
// used to break TM starvation. Purely combinational.
module hsi_prio_arb
    import hsi_pkg::*;
(
    input  logic [3:0] req,
    input  logic       force_tm,
    output logic [3:0] grant_oh,
    output logic [1:0] grant_idx
);

    // Pick the winner; TM jumps the queue only when forced and requesting
    always_comb begin
        grant_oh  = 4'b0000;
        grant_idx = SRC_BTC;
        if (force_tm && req[SRC_TM]) begin
            grant_oh  = 4'b1000;
            grant_idx = SRC_TM;
        end else if (req[SRC_BTC]) begin
            grant_oh  = 4'b0001;
            grant_idx = SRC_BTC;
        end else if (req[SRC_SR]) begin
            grant_oh  = 4'b0010;
            grant_idx = SRC_SR;
        end else if (req[SRC_CCW]) begin
            grant_oh  = 4'b0100;
            grant_idx = SRC_CCW;
        end else if (req[SRC_TM]) begin
            grant_oh  = 4'b1000;
            grant_idx = SRC_TM;
        end
    end

endmodule

// File: rtl/hsi_tx_scheduler.sv
// HSI master transmit scheduler: arbitrates the four frame sources, starts
// one frame at a time on the serializer, retries NAKs, times out hung
// frames and enforces an inter-frame gap.
module hsi_tx_scheduler
    import hsi_pkg::*;
#(
    parameter int GAP_CYC    = 16,
    parameter int MAX_RETRY  = 3,
    parameter int TMO_CYC    = 4096,
    parameter int STARVE_LIM = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btc_en,
    input  logic       btc_rdy,
    output logic       btc_ack,
    input  logic       sr_en,
    input  logic       sr_tx_rdy,
    output logic       sr_tx_ack,
    input  logic       ccw_tx_en,
    input  logic       ccw_tx_rdy,
    output logic       ccw_tx_ack,
    input  logic       tm_tx_en,
    input  logic       tm_tx_rdy,
    output logic       tm_tx_ack,
    output logic       link_start,
    output logic [1:0] link_sel,
    input  logic       link_done,
    input  logic       link_nak,
    output logic       link_abort,
    output logic       fail,
    output logic       busy
);

    localparam int GAP_W    = cnt_width(GAP_CYC);
    localparam int RETRY_W  = cnt_width(MAX_RETRY);
    localparam int TMO_W    = cnt_width(TMO_CYC);
    localparam int STARVE_W = cnt_width(STARVE_LIM);

    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(GAP_CYC - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TMO_CYC - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    logic [2:0]          state;
    logic [1:0]          sel_r;
    logic [GAP_W-1:0]    gap_cnt;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic [3:0] req;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic       force_tm;
    logic       nak_giveup;
    logic       tmo_hit;

    assign req = {tm_tx_en & tm_tx_rdy, ccw_tx_en & ccw_tx_rdy,
                  sr_en & sr_tx_rdy, btc_en & btc_rdy};
    assign force_tm = (starve_cnt == STARVE_MAX);

    hsi_prio_arb u_arb (
        .req       (req),
        .force_tm  (force_tm),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // Abort conditions while waiting; link_done always takes precedence
    assign nak_giveup = (state == ST_WAIT) && !link_done && link_nak && (retry_cnt == RETRY_MAX);
    assign tmo_hit    = (state == ST_WAIT) && !link_done && !link_nak && (tmo_cnt == TMO_LAST);

    // Output decode: grants and starts come straight from the state
    always_comb begin
        btc_ack    = (state == ST_GRANT) && (sel_r == SRC_BTC);
        sr_tx_ack  = (state == ST_GRANT) && (sel_r == SRC_SR);
        ccw_tx_ack = (state == ST_GRANT) && (sel_r == SRC_CCW);
        tm_tx_ack  = (state == ST_GRANT) && (sel_r == SRC_TM);
        link_start = (state == ST_GRANT) || (state == ST_RETRY);
        link_sel   = sel_r;
        link_abort = nak_giveup || tmo_hit;
        fail       = nak_giveup || tmo_hit;
        busy       = (state != ST_IDLE);
    end

    // Scheduler FSM with gap, timeout, retry and starvation counters
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            sel_r      <= SRC_BTC;
            gap_cnt    <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant_oh) begin
                        sel_r <= grant_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    tmo_cnt   <= '0;
                    retry_cnt <= '0;
                    if (sel_r == SRC_TM)
                        starve_cnt <= '0;
                    else if (req[SRC_TM] && (starve_cnt != STARVE_MAX))
                        starve_cnt <= starve_cnt + 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (link_done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (link_nak) begin
                        if (retry_cnt != RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_RETRY;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RETRY: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsi_tx_scheduler.sv
// Directed testbench for hsi_tx_scheduler with default parameters.
// Output vector order: {btc,sr,ccw,tm ack, link_start, link_sel[1:0], link_abort, fail, busy}
module tb_hsi_tx_scheduler;

    localparam int GAP = 16;
    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       btc_en, btc_rdy, sr_en, sr_tx_rdy, ccw_tx_en, ccw_tx_rdy, tm_tx_en, tm_tx_rdy;
    logic       link_done, link_nak;
    logic       btc_ack, sr_tx_ack, ccw_tx_ack, tm_tx_ack;
    logic       link_start, link_abort, fail, busy;
    logic [1:0] link_sel;

    int vectors    = 0;
    int miscompares = 0;

    logic [9:0] obs;
    logic [9:0] exp_v;

    localparam logic [9:0] G_BTC = 10'b1000_1_00_001;
    localparam logic [9:0] G_SR  = 10'b0100_1_01_001;
    localparam logic [9:0] G_CCW = 10'b0010_1_10_001;
    localparam logic [9:0] G_TM  = 10'b0001_1_11_001;

    assign obs = {btc_ack, sr_tx_ack, ccw_tx_ack, tm_tx_ack, link_start, link_sel,
                  link_abort, fail, busy};

    always #5 clk = ~clk;

    hsi_tx_scheduler dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .btc_en     (btc_en),
        .btc_rdy    (btc_rdy),
        .btc_ack    (btc_ack),
        .sr_en      (sr_en),
        .sr_tx_rdy  (sr_tx_rdy),
        .sr_tx_ack  (sr_tx_ack),
        .ccw_tx_en  (ccw_tx_en),
        .ccw_tx_rdy (ccw_tx_rdy),
        .ccw_tx_ack (ccw_tx_ack),
        .tm_tx_en   (tm_tx_en),
        .tm_tx_rdy  (tm_tx_rdy),
        .tm_tx_ack  (tm_tx_ack),
        .link_start (link_start),
        .link_sel   (link_sel),
        .link_done  (link_done),
        .link_nak   (link_nak),
        .link_abort (link_abort),
        .fail       (fail),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From WAIT: pulse link_done and run out the gap, ending in IDLE
    task automatic done_and_gap();
        link_done = 1'b1;
        tick();
        link_done = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        btc_en = 1'b0; btc_rdy = 1'b0; sr_en = 1'b0; sr_tx_rdy = 1'b0;
        ccw_tx_en = 1'b0; ccw_tx_rdy = 1'b0; tm_tx_en = 1'b0; tm_tx_rdy = 1'b0;
        link_done = 1'b0; link_nak = 1'b0;
        repeat (3) tick();
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
        end
        n_rst = 1'b1;
        btc_en = 1'b1; sr_en = 1'b1; ccw_tx_en = 1'b1; tm_tx_en = 1'b1;
        tick();
    endtask

    task automatic test_priority_gap();
        btc_rdy = 1'b1; tm_tx_rdy = 1'b1;
        tick();
        vectors++;
        if (obs !== G_BTC) begin
            miscompares++;
            $display("FAIL prio_btc_grant: got %b want %b", obs, G_BTC);
        end
        btc_rdy = 1'b0;
        tick();
        exp_v = 10'b0000_0_00_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL prio_btc_wait: got %b want %b", obs, exp_v);
        end
        link_done = 1'b1;
        tick();
        link_done = 1'b0;
        repeat (GAP - 1) tick();
        exp_v = 10'b0000_0_00_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL gap_last_cycle: got %b want %b", obs, exp_v);
        end
        tick();
        exp_v = 10'b0000_0_00_000;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL gap_to_idle: got %b want %b", obs, exp_v);
        end
        tick();
        vectors++;
        if (obs !== G_TM) begin
            miscompares++;
            $display("FAIL tm_after_gap: got %b want %b", obs, G_TM);
        end
        tm_tx_rdy = 1'b0;
        tick();
        done_and_gap();
    endtask

    task automatic test_nak_retry();
        ccw_tx_rdy = 1'b1;
        tick();
        vectors++;
        if (obs !== G_CCW) begin
            miscompares++;
            $display("FAIL ccw_grant: got %b want %b", obs, G_CCW);
        end
        ccw_tx_rdy = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            link_nak = 1'b1;
            tick();
            link_nak = 1'b0;
            exp_v = 10'b0000_1_10_001;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL ccw_retry_start[%0d]: got %b want %b", i, obs, exp_v);
            end
            tick();
            exp_v = 10'b0000_0_10_001;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL ccw_retry_wait[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        link_done = 1'b1; link_nak = 1'b1;
        #1;
        exp_v = 10'b0000_0_10_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL done_nak_no_abort: got %b want %b", obs, exp_v);
        end
        tick();
        link_done = 1'b0; link_nak = 1'b0;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL done_wins_gap: got %b want %b", obs, exp_v);
        end
        repeat (GAP) tick();
    endtask

    task automatic test_retry_exhaust();
        sr_tx_rdy = 1'b1;
        tick();
        vectors++;
        if (obs !== G_SR) begin
            miscompares++;
            $display("FAIL sr_grant: got %b want %b", obs, G_SR);
        end
        sr_tx_rdy = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            link_nak = 1'b1;
            #1;
            exp_v = 10'b0000_0_01_001;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sr_nak_no_abort[%0d]: got %b want %b", i, obs, exp_v);
            end
            tick();
            link_nak = 1'b0;
            exp_v = 10'b0000_1_01_001;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sr_retry_start[%0d]: got %b want %b", i, obs, exp_v);
            end
            tick();
        end
        link_nak = 1'b1;
        #1;
        exp_v = 10'b0000_0_01_111;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL sr_abort_fail: got %b want %b", obs, exp_v);
        end
        tick();
        link_nak = 1'b0;
        exp_v = 10'b0000_0_01_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL sr_abort_gap: got %b want %b", obs, exp_v);
        end
        repeat (GAP) tick();
        exp_v = 10'b0000_0_01_000;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL sr_back_idle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_timeout();
        btc_rdy = 1'b1;
        tick();
        vectors++;
        if (obs !== G_BTC) begin
            miscompares++;
            $display("FAIL tmo_grant: got %b want %b", obs, G_BTC);
        end
        btc_rdy = 1'b0;
        repeat (TMO - 1) tick();
        exp_v = 10'b0000_0_00_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL tmo_early: got %b want %b", obs, exp_v);
        end
        tick();
        exp_v = 10'b0000_0_00_111;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL tmo_abort: got %b want %b", obs, exp_v);
        end
        tick();
        exp_v = 10'b0000_0_00_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL tmo_gap: got %b want %b", obs, exp_v);
        end
        repeat (GAP) tick();
    endtask

    task automatic test_starvation();
        sr_tx_rdy = 1'b1; tm_tx_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_v = (k == 4 || k == 9) ? G_TM : G_SR;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL starve_grant[%0d]: got %b want %b", k, obs, exp_v);
            end
            tick();
            done_and_gap();
        end
        sr_tx_rdy = 1'b0; tm_tx_rdy = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        ccw_tx_rdy = 1'b1;
        tick();
        ccw_tx_rdy = 1'b0;
        tick();
        exp_v = 10'b0000_0_10_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL midrst_wait: got %b want %b", obs, exp_v);
        end
        n_rst = 1'b0;
        tick();
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b want %b", obs, 10'b0);
        end
        n_rst = 1'b1;
        ccw_tx_rdy = 1'b1;
        tick();
        vectors++;
        if (obs !== G_CCW) begin
            miscompares++;
            $display("FAIL midrst_regrant: got %b want %b", obs, G_CCW);
        end
        ccw_tx_rdy = 1'b0;
        ccw_tx_en = 1'b0;
        tick();
        exp_v = 10'b0000_0_10_001;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL en_drop_inflight: got %b want %b", obs, exp_v);
        end
        done_and_gap();
        ccw_tx_en = 1'b1;
    endtask

    task automatic test_enable_mask();
        btc_en = 1'b0; btc_rdy = 1'b1;
        tick();
        tick();
        exp_v = 10'b0000_0_10_000;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL disabled_no_grant: got %b want %b", obs, exp_v);
        end
        btc_rdy = 1'b0; btc_en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority_gap();
        test_nak_retry();
        test_retry_exhaust();
        test_timeout();
        test_starvation();
        test_reset_midframe();
        test_enable_mask();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
